// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout and the ALUOp/NPCOp/WDSel
// encodings used by the decoder, the ID/EX register and EX.
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 20;

   // Bit offsets inside the packed control bundle (MSB first).
   localparam int CTRL_REGWRITE   = 19;
   localparam int CTRL_MEMWRITE   = 18;
   localparam int CTRL_MEMREAD    = 17;
   localparam int CTRL_ALUOP_MSB  = 16;
   localparam int CTRL_ALUOP_LSB  = 12;
   localparam int CTRL_NPCOP_MSB  = 11;
   localparam int CTRL_NPCOP_LSB  = 7;
   localparam int CTRL_ALUSRC     = 6;
   localparam int CTRL_WDSEL_MSB  = 5;
   localparam int CTRL_WDSEL_LSB  = 4;
   localparam int CTRL_BRANCH     = 3;
   localparam int CTRL_FUNCT3_MSB = 2;
   localparam int CTRL_FUNCT3_LSB = 0;

   typedef enum logic [4:0] {
      ALU_NOP  = 5'd0,
      ALU_ADD  = 5'd1,
      ALU_SUB  = 5'd2,
      ALU_AND  = 5'd3,
      ALU_OR   = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SLL  = 5'd6,
      ALU_SRL  = 5'd7,
      ALU_SRA  = 5'd8,
      ALU_SLT  = 5'd9,
      ALU_SLTU = 5'd10,
      ALU_LUI  = 5'd11,
      ALU_AUIPC = 5'd12
   } alu_op_e;

   // PLUS4 must stay at zero so that an all-zero bundle is a NOP.
   typedef enum logic [4:0] {
      NPC_PLUS4  = 5'd0,
      NPC_BRANCH = 5'd1,
      NPC_JAL    = 5'd2,
      NPC_JALR   = 5'd3
   } npc_op_e;

   typedef enum logic [1:0] {
      WD_ALU = 2'd0,
      WD_MEM = 2'd1,
      WD_PC4 = 2'd2
   } wd_sel_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      alu_op_e    alu_op;
      npc_op_e    npc_op;
      logic       alu_src;
      wd_sel_e    wd_sel;
      logic       is_branch;
      logic [2:0] funct3;
   } ctrl_t;

   // Writes to x0 are architecturally void; drop them as early as possible.
   function automatic ctrl_t ctrl_mask_x0(input ctrl_t ctrl, input logic [REG_AW-1:0] rd);
      ctrl_t c;
      c = ctrl;
      c.reg_write = ctrl.reg_write & (rd != {REG_AW{1'b0}});
      return c;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose rd is read by the ID instruction.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW_P = REG_AW
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW_P-1:0] ex_rd_i,
   input  logic              id_valid_i,
   input  logic              id_use_rs1_i,
   input  logic [REG_AW_P-1:0] id_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW_P-1:0] id_rs2_i,
   output logic              load_use_o
);

   logic ex_load_s;
   logic rs1_hit_s;
   logic rs2_hit_s;

   // x0 never carries a dependency, so a load to x0 cannot cause a hazard.
   always_comb begin
      ex_load_s  = ex_valid_i & ex_mem_read_i & (ex_rd_i != {REG_AW_P{1'b0}});
      rs1_hit_s  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
      rs2_hit_s  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
      load_use_o = ex_load_s & id_valid_i & (rs1_hit_s | rs2_hit_s);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and hold handling.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a load-use bubble counter output.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN   = pipe_pkg::XLEN,
   parameter int REG_AW = pipe_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic              flush_i,
   input  logic              hold_i,
   output logic              stall_o,
   output logic              ex_valid_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [REG_AW-1:0] ex_rs1_o,
   output logic [REG_AW-1:0] ex_rs2_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [CTRL_W-1:0] ex_ctrl_o
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]       bubble_cnt_o
`endif
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      ctrl_t             ctrl;
   } stage_t;

   stage_t stage_q;
   stage_t stage_d;
   ctrl_t  ex_ctrl_s;
   ctrl_t  id_ctrl_s;
   logic   load_use_s;
   logic   lu_bubble_s;

   assign ex_ctrl_s = ctrl_t'(stage_q.ctrl);
   assign id_ctrl_s = ctrl_t'(id_ctrl_i);

   hazard_detect #(
      .REG_AW_P (REG_AW)
   ) u_hazard_detect (
      .ex_valid_i    (stage_q.valid),
      .ex_mem_read_i (ex_ctrl_s.mem_read),
      .ex_rd_i       (stage_q.rd),
      .id_valid_i    (id_valid_i),
      .id_use_rs1_i  (id_use_rs1_i),
      .id_rs1_i      (id_rs1_i),
      .id_use_rs2_i  (id_use_rs2_i),
      .id_rs2_i      (id_rs2_i),
      .load_use_o    (load_use_s)
   );

   // A flush discards the dependent instruction, so it also cancels the stall.
   always_comb begin
      stall_o     = ~flush_i & (load_use_s | hold_i);
      lu_bubble_s = ~flush_i & ~hold_i & load_use_s;
   end

   // Next-state selection: flush > hold > load-use bubble > capture.
   always_comb begin
      stage_d = stage_q;
      if (flush_i) begin
         stage_d = '0;
      end else if (hold_i) begin
         stage_d = stage_q;
      end else if (load_use_s) begin
         stage_d = '0;
      end else begin
         stage_d.valid    = id_valid_i;
         stage_d.pc       = id_pc_i;
         stage_d.rs1_data = id_rs1_data_i;
         stage_d.rs2_data = id_rs2_data_i;
         stage_d.imm      = id_imm_i;
         stage_d.rs1      = id_rs1_i;
         stage_d.rs2      = id_rs2_i;
         stage_d.rd       = id_rd_i;
         if (id_valid_i) begin
            stage_d.ctrl = ctrl_mask_x0(id_ctrl_s, id_rd_i);
         end else begin
            stage_d.ctrl = '0;
         end
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ex_valid_o    = stage_q.valid;
   assign ex_pc_o       = stage_q.pc;
   assign ex_rs1_data_o = stage_q.rs1_data;
   assign ex_rs2_data_o = stage_q.rs2_data;
   assign ex_imm_o      = stage_q.imm;
   assign ex_rs1_o      = stage_q.rs1;
   assign ex_rs2_o      = stage_q.rs2;
   assign ex_rd_o       = stage_q.rd;
   assign ex_ctrl_o     = stage_q.ctrl;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] bubble_cnt_d;

   // Only load-use bubbles are counted; wraps naturally at 2^32.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (lu_bubble_s) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bubble_cnt_q <= 32'd0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`else
   logic unused_s;
   assign unused_s = lu_bubble_s;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic
// checked against a rule-level model of the EX slot.
module tb_id_ex_stage;
   import pipe_pkg::*;

   logic        clk;
   logic        rstn;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2;
   logic [19:0] id_ctrl;
   logic        flush, hold;
   logic        stall_o, ex_valid_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic [19:0] ex_ctrl_o;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_o;
`endif

   id_ex_stage dut (
      .clk           (clk),
      .rstn          (rstn),
      .id_valid_i    (id_valid),
      .id_pc_i       (id_pc),
      .id_rs1_data_i (id_rs1_data),
      .id_rs2_data_i (id_rs2_data),
      .id_imm_i      (id_imm),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_rd_i       (id_rd),
      .id_use_rs1_i  (id_use_rs1),
      .id_use_rs2_i  (id_use_rs2),
      .id_ctrl_i     (id_ctrl),
      .flush_i       (flush),
      .hold_i        (hold),
      .stall_o       (stall_o),
      .ex_valid_o    (ex_valid_o),
      .ex_pc_o       (ex_pc_o),
      .ex_rs1_data_o (ex_rs1_data_o),
      .ex_rs2_data_o (ex_rs2_data_o),
      .ex_imm_o      (ex_imm_o),
      .ex_rs1_o      (ex_rs1_o),
      .ex_rs2_o      (ex_rs2_o),
      .ex_rd_o       (ex_rd_o),
      .ex_ctrl_o     (ex_ctrl_o)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .bubble_cnt_o  (bubble_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model of the EX slot contents
   logic        m_valid;
   logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [19:0] m_ctrl;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input bit clr_cnt);
      m_valid = 1'b0; m_pc = 32'd0; m_rs1d = 32'd0; m_rs2d = 32'd0; m_imm = 32'd0;
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_ctrl = 20'd0;
      if (clr_cnt) m_cnt = 32'd0;
   endtask

   function automatic bit model_lu();
      bit hit;
      hit = (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
      return m_valid && m_ctrl[CTRL_MEMREAD] && (m_rd != 5'd0) && id_valid && hit;
   endfunction

   function automatic bit model_stall();
      return !flush && (model_lu() || hold);
   endfunction

   task automatic model_step();
      if (flush) begin
         model_clear(1'b0);
      end else if (hold) begin
         m_valid = m_valid;
      end else if (model_lu()) begin
         model_clear(1'b0);
         m_cnt = m_cnt + 32'd1;
      end else begin
         m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
         m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
         m_ctrl = id_valid ? id_ctrl : 20'd0;
         if (id_rd == 5'd0) m_ctrl[CTRL_REGWRITE] = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, {31'd0, ex_valid_o}, {31'd0, m_valid});
      chk({tag, ".pc"}, ex_pc_o, m_pc);
      chk({tag, ".rs1d"}, ex_rs1_data_o, m_rs1d);
      chk({tag, ".rs2d"}, ex_rs2_data_o, m_rs2d);
      chk({tag, ".imm"}, ex_imm_o, m_imm);
      chk({tag, ".idx"}, {17'd0, ex_rs1_o, ex_rs2_o, ex_rd_o}, {17'd0, m_rs1, m_rs2, m_rd});
      chk({tag, ".ctrl"}, {12'd0, ex_ctrl_o}, {12'd0, m_ctrl});
`ifdef ID_EX_BUBBLE_CNT_EN
      chk({tag, ".cnt"}, bubble_cnt_o, m_cnt);
`endif
   endtask

   // One clock: stall checked mid-cycle, registers checked just after the edge.
   task automatic cycle(input string tag);
      @(negedge clk);
      chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, model_stall()});
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   function automatic logic [19:0] mk(input bit rw, input bit mw, input bit mr,
                                      input logic [2:0] f3);
      ctrl_t c;
      c = '0;
      c.reg_write = rw; c.mem_write = mw; c.mem_read = mr;
      c.alu_op = ALU_ADD; c.wd_sel = mr ? WD_MEM : WD_ALU; c.funct3 = f3;
      return c;
   endfunction

   task automatic set_id(input bit v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bit u1, input bit u2, input logic [19:0] ctrl);
      id_valid = v; id_pc = pc; id_imm = imm; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl;
      id_rs1_data = 32'hA000_0000 | pc; id_rs2_data = 32'hB000_0000 | pc;
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; hold = 1'b0;
      set_id(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 20'd0);
      model_clear(1'b1);
      #12;
      check_all("reset");
      chk("reset.stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;

      // addi x1,x0,5
      set_id(1'b1, 32'h0, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'b000));
      cycle("addi");
      chk("addi.rd", {27'd0, ex_rd_o}, 32'd1);
      chk("addi.imm", ex_imm_o, 32'd5);
      chk("addi.rw", {31'd0, ex_ctrl_o[CTRL_REGWRITE]}, 32'd1);

      // lw x5 then dependent add x6,x5,x2
      set_id(1'b1, 32'h4, 32'd0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'b010));
      cycle("lw5");
      set_id(1'b1, 32'h8, 32'd0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3'b000));
      #1 chk("lu.stall_on", {31'd0, stall_o}, 32'd1);
      cycle("lu_bubble");
      chk("lu.bubble_valid", {31'd0, ex_valid_o}, 32'd0);
      #1 chk("lu.stall_off", {31'd0, stall_o}, 32'd0);
      cycle("lu_add");
      chk("lu.add_rd", {27'd0, ex_rd_o}, 32'd6);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("lu.cnt", bubble_cnt_o, 32'd1);
`endif

      // load to x0 never stalls; writes to x0 are dropped
      set_id(1'b1, 32'hC, 32'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'b010));
      cycle("lw0");
      set_id(1'b1, 32'h10, 32'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3'b000));
      #1 chk("x0.nostall", {31'd0, stall_o}, 32'd0);
      cycle("add_x0");
      set_id(1'b1, 32'h14, 32'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'b000));
      cycle("addi_x0");
      chk("x0.rw", {31'd0, ex_ctrl_o[CTRL_REGWRITE]}, 32'd0);

      // flush together with a load-use hazard
      set_id(1'b1, 32'h18, 32'd0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'b010));
      cycle("lw5b");
      set_id(1'b1, 32'h1C, 32'd0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3'b000));
      flush = 1'b1;
      #1 chk("flush.stall", {31'd0, stall_o}, 32'd0);
      cycle("flush_lu");
      flush = 1'b0;
      chk("flush.ctrl", {12'd0, ex_ctrl_o}, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("flush.cnt", bubble_cnt_o, 32'd1);
`endif

      // hold for three cycles with ex_pc=0x100
      set_id(1'b1, 32'h100, 32'd7, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3'b000));
      cycle("pre_hold");
      set_id(1'b1, 32'h104, 32'd8, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 3'b000));
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold.stall", {31'd0, stall_o}, 32'd1);
         cycle("hold");
         chk("hold.pc", ex_pc_o, 32'h100);
      end
      hold = 1'b0;
      cycle("post_hold");
      chk("hold.release_pc", ex_pc_o, 32'h104);

      // invalid ID carrying MemWrite
      set_id(1'b0, 32'h108, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 3'b010));
      cycle("invalid");
      chk("invalid.ctrl", {12'd0, ex_ctrl_o}, 32'd0);

      // asynchronous reset mid-run
      set_id(1'b1, 32'h200, 32'd9, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'b000));
      cycle("pre_rst");
      chk("pre_rst.valid", {31'd0, ex_valid_o}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      model_clear(1'b1);
      check_all("async_rst");
      @(posedge clk); #1;
      rstn = 1'b1;
      set_id(1'b1, 32'h0, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'b000));
      cycle("addi2");
      chk("addi2.rd", {27'd0, ex_rd_o}, 32'd1);
      chk("addi2.imm", ex_imm_o, 32'd5);
      chk("addi2.rw", {31'd0, ex_ctrl_o[CTRL_REGWRITE]}, 32'd1);

      // random traffic, small register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         id_valid    = ($urandom_range(0, 3) != 0);
         id_pc       = $urandom;
         id_rs1_data = $urandom;
         id_rs2_data = $urandom;
         id_imm      = $urandom;
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_rd       = 5'($urandom_range(0, 3));
         id_use_rs1  = $urandom_range(0, 1) == 1;
         id_use_rs2  = $urandom_range(0, 1) == 1;
         id_ctrl     = 20'($urandom);
         if ($urandom_range(0, 1) == 1) id_ctrl[CTRL_MEMREAD] = 1'b1;
         flush       = ($urandom_range(0, 7) == 0);
         hold        = ($urandom_range(0, 7) == 0);
         cycle("rand");
      end
      flush = 1'b0; hold = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the ID stage (instruction decoder plus register-file read) and the EX stage of the 5-stage RV32I core.
- Captures the decoded control bundle, operands, immediate and register indices each cycle.
- Detects load-use hazards, stalls PC and IF/ID on a hazard, and inserts a bubble.
- Applies flush from EX branch/jump resolution. Branch condition evaluation happens in EX, so funct3 and a branch flag travel with the bundle.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.
- CTRL_W, 20, width of the control bundle; taken from the package constant and not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  PC of the ID instruction
- id_rs1_data_i  in  XLEN  register-file read data, rs1
- id_rs2_data_i  in  XLEN  register-file read data, rs2
- id_imm_i  in  XLEN  extended immediate
- id_rs1_i  in  REG_AW  rs1 index
- id_rs2_i  in  REG_AW  rs2 index
- id_rd_i  in  REG_AW  rd index
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_ctrl_i  in  CTRL_W  packed control bundle: RegWrite, MemWrite, MemRead, ALUOp[4:0], NPCOp[4:0], ALUSrc, WDSel[1:0], is_branch, funct3[2:0]
- flush_i  in  1  EX redirect (taken branch, jal or jalr)
- hold_i  in  1  global freeze from downstream (e.g. memory wait)
- stall_o  out  1  freeze PC and IF/ID this cycle
- ex_valid_o  out  1  EX slot holds a real instruction
- ex_pc_o  out  XLEN  registered PC
- ex_rs1_data_o  out  XLEN  registered rs1 data
- ex_rs2_data_o  out  XLEN  registered rs2 data
- ex_imm_o  out  XLEN  registered immediate
- ex_rs1_o  out  REG_AW  registered rs1 index
- ex_rs2_o  out  REG_AW  registered rs2 index
- ex_rd_o  out  REG_AW  registered rd index
- ex_ctrl_o  out  CTRL_W  registered control bundle

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: every ex_* output is 0, including ex_valid_o=0. The all-zero ctrl bundle is a NOP (no writes, NPCOp = PLUS4). stall_o follows its combinational equation.
- Load-use hazard (combinational), load_use =
  - ex_valid_o & ex_ctrl.MemRead & (ex_rd_o != 0) & id_valid_i &
  - ((id_use_rs1_i & id_rs1_i == ex_rd_o) | (id_use_rs2_i & id_rs2_i == ex_rd_o)).
- Stall output: stall_o = ~flush_i & (load_use | hold_i).
- Update priority per clock edge, highest first:
  1. flush_i: load a bubble (all fields 0, ex_valid_o=0).
  2. hold_i: retain all registers.
  3. load_use: load a bubble. ID is frozen by stall_o, so the dependent instruction re-presents next cycle, when it no longer matches.
  4. Otherwise: capture all ID inputs; ex_valid_o = id_valid_i.
- Bubble on an invalid ID: when id_valid_i=0 at capture, the ctrl bundle is forced to 0.
- x0 write suppression: on capture, the RegWrite bit is stored as RegWrite & (id_rd_i != 0).
- Latency: exactly one cycle from ID to EX. Capture involves no arithmetic.
- flush_i together with load_use: flush wins and stall_o=0. The younger dependent instruction is being discarded anyway.
- flush_i together with hold_i: flush wins. The redirect must not be lost.
- Reset asserted mid-operation: registers clear immediately, with no dependence on the clock.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt_o [31:0], reset to 0. It increments by 1 on each clock edge where a load-use bubble is inserted (priority 3 above), wraps from 0xFFFFFFFF to 0, and excludes flush bubbles.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W
  - bit offsets for each ctrl field (CTRL_REGWRITE, CTRL_ALUOP_LSB, …)
  - ALUOp, NPCOp and WDSel encodings, shared with the decoder and EX.
- One natural sub-module, hazard_detect: pure combinational load_use logic, reused later by forwarding.

Test Plan:
- Reset: rstn=0 mid-run with ex_valid_o=1 → all ex_* outputs 0 at once, without a clock edge. Release, then capture of addi x1,x0,5 → ex_rd_o=1, ex_imm_o=5, RegWrite=1 one cycle later.
- Load-use: lw x5 in EX, then add x6,x5,x2 in ID → stall_o=1 for exactly one cycle, ex_valid_o=0 bubble, then add is captured. With ID_EX_BUBBLE_CNT_EN, bubble_cnt_o=1.
- x0: lw x0 in EX, then add x1,x0,x0 in ID → no stall. Capturing addi x0,x0,1 → stored RegWrite=0.
- Flush with hazard: flush_i=1 while load_use=1 → stall_o=0, bubble loaded, counter unchanged.
- Hold: hold_i=1 for 3 cycles with ex_pc_o=0x100 → outputs constant and stall_o=1. Release → capture of the next ID instruction.
- Invalid ID: id_valid_i=0 with id_ctrl_i MemWrite=1 → ex_ctrl_o=0 and ex_valid_o=0.
